// File: rtl/motor_ramp_if.sv
// Request/command bundle between the motor register bank, the ramp sequencer and pwm_dir.
// The master side issues requests and reads back the ramped commands; the slave is motor_ramp.
interface motor_ramp_if;
  logic       en_in;
  logic       float_in;
  logic       dir_in;
  logic [6:0] duty_in;
  logic       en_out;
  logic       float_out;
  logic       dir_out;
  logic [6:0] duty_out;
  logic       at_target;
  logic       busy;

  modport master (
    output en_in, float_in, dir_in, duty_in,
    input  en_out, float_out, dir_out, duty_out, at_target, busy
  );

  modport slave (
    input  en_in, float_in, dir_in, duty_in,
    output en_out, float_out, dir_out, duty_out, at_target, busy
  );
endinterface

// File: rtl/motor_ramp.sv
// Duty slew limiter and safe-reversal sequencer feeding one pwm_dir instance.
//   state | meaning
//   TRACK | step duty toward target once per tick, same direction
//   BRAKE | direction change pending, ramping duty down to zero
//   DEAD  | duty at zero, counting dead-time ticks before flipping direction
module motor_ramp #(
  parameter int CLK_FREQUENCY  = 60_000_000,
  parameter int STEP_FREQUENCY = 1_000,
  parameter int MAX_DUTY       = 100,
  parameter int DEADTIME_STEPS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  motor_ramp_if.slave  bus
);

  localparam int DIV = CLK_FREQUENCY / STEP_FREQUENCY;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(DEADTIME_STEPS + 1);
  localparam logic [6:0]    MAXD   = 7'(MAX_DUTY);
  localparam logic [PW-1:0] PS_TOP = PW'(DIV - 1);
  localparam logic [DW-1:0] DEAD_N = DW'(DEADTIME_STEPS);

  typedef enum logic [1:0] {TRACK, BRAKE, DEAD} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [DW-1:0] dead_cnt;
  logic [6:0]    duty_q;
  logic          dir_q;
  logic          en_q;
  logic          float_q;

  logic       tick;
  logic       override;
  logic [6:0] tgt;
  logic [6:0] tgt_eff;

  assign tick     = (prescaler == PS_TOP);
  assign override = ~bus.en_in | bus.float_in;
  assign tgt      = (bus.duty_in > MAXD) ? MAXD : bus.duty_in;
  assign tgt_eff  = override ? 7'd0 : tgt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= TRACK;
      dead_cnt <= '0;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      float_q  <= 1'b0;
    end else begin
      en_q    <= bus.en_in;
      float_q <= bus.float_in;
      // Override wins over any state and over a coincident tick.
      if (override) begin
        duty_q   <= '0;
        dir_q    <= bus.dir_in;
        state    <= TRACK;
        dead_cnt <= '0;
      end else begin
        case (state)
          TRACK: begin
            if (bus.dir_in == dir_q) begin
              if (tick) begin
                if (duty_q < tgt) begin
                  duty_q <= duty_q + 1'b1;
                end else if (duty_q > tgt) begin
                  duty_q <= duty_q - 1'b1;
                end
              end
            end else if (duty_q != '0) begin
              state <= BRAKE;
            end else begin
              state    <= DEAD;
              dead_cnt <= DEAD_N;
            end
          end
          BRAKE: begin
            if (bus.dir_in == dir_q) begin
              state <= TRACK;
            end else if (tick && (duty_q != '0)) begin
              duty_q <= duty_q - 1'b1;
              if (duty_q == 7'd1) begin
                state    <= DEAD;
                dead_cnt <= DEAD_N;
              end
            end
          end
          DEAD: begin
            if (bus.dir_in == dir_q) begin
              state    <= TRACK;
              dead_cnt <= '0;
            end else if (tick) begin
              if (dead_cnt <= DW'(1)) begin
                dir_q    <= bus.dir_in;
                state    <= TRACK;
                dead_cnt <= '0;
              end else begin
                dead_cnt <= dead_cnt - 1'b1;
              end
            end
          end
          default: begin
            state    <= TRACK;
            dead_cnt <= '0;
            duty_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.en_out    = en_q;
  assign bus.float_out = float_q;
  assign bus.dir_out   = dir_q;
  assign bus.duty_out  = duty_q;
  assign bus.at_target = (state == TRACK) && (duty_q == tgt_eff) && (dir_q == bus.dir_in);
  assign bus.busy      = ~bus.at_target;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp: reset, ramping, clamp, reversal, aborted reversal, override, reset abort.
// Tick every 10 cycles; cyc counts edges since the last reset release.
module tb_motor_ramp;
  logic clk;
  logic reset_n;
  int   vecs;
  int   errs;
  int   cyc;

  motor_ramp_if bus ();

  motor_ramp #(
    .CLK_FREQUENCY (1000),
    .STEP_FREQUENCY(100),
    .MAX_DUTY      (100),
    .DEADTIME_STEPS(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic to_tick();
    cycles(1);
    while (cyc % 10 != 0) cycles(1);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc  = 0;
    reset_n = 1'b0;
    bus.en_in    = 1'($urandom_range(0, 1));
    bus.float_in = 1'($urandom_range(0, 1));
    bus.dir_in   = 1'($urandom_range(0, 1));
    bus.duty_in  = 7'($urandom_range(0, 127));
    cycles(3);
    chk("rst_duty", int'(bus.duty_out), 0);
    chk("rst_dir", int'(bus.dir_out), 0);
    chk("rst_en", int'(bus.en_out), 0);
    chk("rst_float", int'(bus.float_out), 0);
    bus.en_in = 1'b0; bus.float_in = 1'b0; bus.dir_in = 1'b0; bus.duty_in = 7'd0;
    #1;
    chk("rst_at_target", int'(bus.at_target), 1);
    chk("rst_busy", int'(bus.busy), 0);

    // Release and ramp up to 5
    @(posedge clk); #1;
    reset_n = 1'b1; cyc = 0;
    bus.en_in = 1'b1; bus.duty_in = 7'd5;
    cycles(9);
    chk("pre_first_tick", int'(bus.duty_out), 0);
    chk("en_out", int'(bus.en_out), 1);
    cycles(1);
    chk("first_tick", int'(bus.duty_out), 1);
    for (int d = 2; d <= 5; d++) begin
      to_tick();
      chk("ramp_up", int'(bus.duty_out), d);
      chk("ramp_up_at", int'(bus.at_target), (d == 5) ? 1 : 0);
    end
    bus.duty_in = 7'd2;
    for (int d = 4; d >= 2; d--) begin
      to_tick();
      chk("ramp_down", int'(bus.duty_out), d);
    end
    chk("ramp_down_at", int'(bus.at_target), 1);

    // Clamp at MAX_DUTY
    bus.duty_in = 7'd98;
    for (int i = 0; i < 96; i++) to_tick();
    chk("reach_98", int'(bus.duty_out), 98);
    bus.duty_in = 7'd127;
    to_tick();
    chk("clamp_99", int'(bus.duty_out), 99);
    chk("clamp_99_at", int'(bus.at_target), 0);
    to_tick();
    chk("clamp_100", int'(bus.duty_out), 100);
    chk("clamp_100_at", int'(bus.at_target), 1);
    to_tick();
    chk("clamp_hold", int'(bus.duty_out), 100);

    // Settle at 3 then reverse 0 -> 1
    bus.duty_in = 7'd3;
    for (int i = 0; i < 97; i++) to_tick();
    chk("settle_3", int'(bus.duty_out), 3);
    bus.dir_in = 1'b1;
    for (int d = 2; d >= 0; d--) begin
      to_tick();
      chk("brake_duty", int'(bus.duty_out), d);
      chk("brake_dir", int'(bus.dir_out), 0);
    end
    chk("brake_busy", int'(bus.busy), 1);
    for (int t = 1; t <= 4; t++) begin
      to_tick();
      chk("dead_duty", int'(bus.duty_out), 0);
      chk("dead_dir", int'(bus.dir_out), (t == 4) ? 1 : 0);
    end
    for (int d = 1; d <= 3; d++) begin
      to_tick();
      chk("rev_ramp", int'(bus.duty_out), d);
      chk("rev_dir", int'(bus.dir_out), 1);
    end
    chk("rev_at", int'(bus.at_target), 1);

    // Aborted reversal: request 0, then return to 1 after the 2nd dead tick
    bus.dir_in = 1'b0;
    for (int d = 2; d >= 0; d--) begin
      to_tick();
      chk("abort_brake", int'(bus.duty_out), d);
    end
    to_tick();
    to_tick();
    chk("abort_dead_dir", int'(bus.dir_out), 1);
    bus.dir_in = 1'b1;
    cycles(1);
    chk("abort_dir_kept", int'(bus.dir_out), 1);
    for (int d = 1; d <= 3; d++) begin
      to_tick();
      chk("abort_ramp", int'(bus.duty_out), d);
      chk("abort_no_flip", int'(bus.dir_out), 1);
    end

    // Override mid-ramp at 40
    bus.duty_in = 7'd60;
    for (int i = 0; i < 37; i++) to_tick();
    chk("reach_40", int'(bus.duty_out), 40);
    bus.en_in = 1'b0;
    cycles(1);
    chk("ovr_duty", int'(bus.duty_out), 0);
    chk("ovr_en_out", int'(bus.en_out), 0);
    chk("ovr_at", int'(bus.at_target), 1);

    // Reset during BRAKE
    bus.en_in = 1'b1; bus.duty_in = 7'd5;
    for (int i = 0; i < 5; i++) to_tick();
    chk("pre_brake_5", int'(bus.duty_out), 5);
    bus.dir_in = 1'b0;
    to_tick();
    chk("brake_4", int'(bus.duty_out), 4);
    reset_n = 1'b0;
    cycles(1);
    chk("rb_duty", int'(bus.duty_out), 0);
    chk("rb_dir", int'(bus.dir_out), 0);
    chk("rb_en", int'(bus.en_out), 0);
    reset_n = 1'b1; cyc = 0;
    cycles(10);
    chk("rb_track_duty", int'(bus.duty_out), 1);
    chk("rb_track_dir", int'(bus.dir_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
